des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Iterative DES key-schedule generator that sits directly upstream of the DES round datapath inside `DES_top`. It accepts a 64-bit key over a valid/ready handshake and streams the sixteen 48-bit round subkeys one per transfer. Subkeys are emitted in encryption order (K1..K16) or decryption order (K16..K1). Subkeys are produced by PC-1, per-round rotations and PC-2, with back-pressure from the round engine.

## Interface
- No parameters; all widths are fixed by FIPS 46-3.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `KEY` in 64: DES key; bit 1 (FIPS numbering) is `KEY[63]`; parity bits 8,16,..,64 are ignored.
- `DECRYPT` in 1: sampled with the key; 1 selects K16..K1 order.
- `KEY_VALID` in 1: key offer.
- `KEY_READY` out 1: block can accept a key; high only in IDLE.
- `SUBKEY` out 48: current subkey; FIPS bit 1 is `SUBKEY[47]`.
- `SUBKEY_VALID` out 1: `SUBKEY` and `ROUND` are valid.
- `SUBKEY_READY` in 1: consumer accepts the current subkey.
- `ROUND` out 4: subkey number minus 1 (K1 → 0, K16 → 15).
- `DONE` out 1: one-cycle pulse after the 16th subkey transfer.

## Operation
- Registers: 28-bit `C` and 28-bit `D`, 4-bit step counter `STEP` (0..15), direction flag `DIR`, FSM state.
- **FSM: IDLE → RUN → IDLE.**
  - **IDLE**
    - `KEY_READY`=1 and `SUBKEY_VALID`=0.
    - On `KEY_VALID`&&`KEY_READY`, load `{C,D}` = PC-1(`KEY`) and latch `DIR`=`DECRYPT`.
    - Encrypt: additionally rotate left by 1, so `{C,D}` holds C1D1.
    - Decrypt: no rotation, so `{C,D}` holds C0D0, which equals C16D16.
    - Set `STEP`=0 and go to RUN.
  - **RUN**
    - `SUBKEY_VALID`=1 and `SUBKEY` = PC-2(`{C,D}`), combinational from the registers.
    - `ROUND` = `STEP` when encrypting, 15−`STEP` when decrypting.
    - A transfer occurs when `SUBKEY_VALID`&&`SUBKEY_READY`.
    - No transfer: all state holds; `SUBKEY` and `ROUND` stay stable.
    - Transfer with `STEP`<15, encrypt (current Kn → next Kn+1): rotate C and D left by shift(n+1).
    - Transfer with `STEP`<15, decrypt (current Kn → next Kn−1): rotate C and D right by shift(n).
    - In both directions `STEP` increments on every non-final transfer.
    - Transfer with `STEP`=15: go to IDLE and pulse `DONE` on the following cycle.
- Shift schedule: shift(n)=1 for n ∈ {1,2,9,16}, otherwise 2. Cumulative left rotation is 28, so C16D16 = C0D0.
- `KEY` and `DECRYPT` are ignored outside IDLE; a new key is never accepted mid-schedule.
- PC-1 and PC-2 are the standard FIPS 46-3 tables using the bit mapping given under Interface.

## Timing
- Reset values:
  - `SUBKEY_VALID`=0, `DONE`=0, `ROUND`=0, `SUBKEY`=0.
  - State IDLE, so `KEY_READY`=1.
  - `C`=0, `D`=0, `STEP`=0, `DIR`=0.
- Reset asserted mid-schedule aborts immediately (asynchronously) to these values; no `DONE` is produced.
- Latency: key accepted at edge t → first subkey valid in the cycle after edge t.
- With `SUBKEY_READY` held high, 16 subkeys appear on 16 consecutive cycles.
  - `DONE`=1 in the cycle after the last transfer, coinciding with `KEY_READY`=1.
  - A new key may be accepted in that same cycle, giving a 17-cycle key-to-key period with 1 idle subkey slot.
- `SUBKEY_READY` may toggle arbitrarily. Each low cycle stretches the schedule by one cycle; no subkey is skipped or duplicated.
- `SUBKEY_READY` while `SUBKEY_VALID`=0 has no effect.
- `ROUND` wraps only by returning to IDLE; `STEP` never exceeds 15.

## Test plan
- Encrypt, `KEY`=133457799BBCDFF1, `DECRYPT`=0, ready held high → three checks:
  - K1=1B02EFFC7072 at `ROUND`=0, first valid cycle after accept.
  - K2=79AED9DBC9E5 at `ROUND`=1.
  - K16=CB3D8B0E17F5 at `ROUND`=15, 16th valid cycle; `DONE` pulses exactly once one cycle later.
- Decrypt, same key, `DECRYPT`=1 → first subkey CB3D8B0E17F5 with `ROUND`=15; second has `ROUND`=14; last is 1B02EFFC7072 with `ROUND`=0.
- Back-pressure: `SUBKEY_READY` random at 50% → transferred sequence identical to the ready-high case; `SUBKEY` and `ROUND` are stable on every stalled cycle.
- Parity independence and busy protection: `KEY`=123456789ABCDEF1 (parity bits differ) → identical subkeys to 133457799BBCDFF1. `KEY_VALID` pulsed during RUN with another key → `KEY_READY`=0 and the schedule is unaffected.
- Reset mid-operation: assert `RST_N`=0 after the 5th transfer → all outputs take their reset values immediately. After release, new key 0E329232EA6D0D73 in encrypt → full 16-subkey run completes correctly from K1.
- Back-to-back keys: second key offered continuously → accepted in the `DONE` cycle; its K1 is valid the next cycle.

Source files
------------

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on key load, per-round C/D rotation, PC-2 on output.
// Streams K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake.
module des_key_schedule (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] KEY,
  input  logic        DECRYPT,
  input  logic        KEY_VALID,
  output logic        KEY_READY,
  output logic [47:0] SUBKEY,
  output logic        SUBKEY_VALID,
  input  logic        SUBKEY_READY,
  output logic [3:0]  ROUND,
  output logic        DONE
);

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned SK_W   = 48;
  localparam int unsigned STEP_W = 4;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(15);

  // FIPS 46-3 permutation tables, 1-based bit numbers with bit 1 as MSB.
  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [SK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [HALF_W-1:0]   c;
  logic [HALF_W-1:0]   d;
  logic [HALF_W-1:0]   c_nxt;
  logic [HALF_W-1:0]   d_nxt;
  logic [STEP_W-1:0]   step;
  logic                dir;
  logic                one_shift;
  logic                xfer;
  logic [CD_W-1:0]     key_cd;

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < CD_W; j++)
      r[6'(CD_W - 1 - j)] = k[6'(KEY_W - PC1_TAB[6'(j)])];
    return r;
  endfunction

  function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SK_W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < SK_W; j++)
      r[6'(SK_W - 1 - j)] = cd[6'(CD_W - PC2_TAB[6'(j)])];
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic one);
    return one ? {x[HALF_W-2:0], x[HALF_W-1]} : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic one);
    return one ? {x[0], x[HALF_W-1:1]} : {x[1:0], x[HALF_W-1:2]};
  endfunction

  assign key_cd       = pc1(KEY);
  assign SUBKEY       = pc2({c, d});
  assign KEY_READY    = (state == IDLE);
  assign SUBKEY_VALID = (state == RUN);
  assign xfer         = (state == RUN) && SUBKEY_READY;

  // Steps 0, 7 and 14 move across single-shift rounds in both directions.
  assign one_shift = (step == STEP_W'(0)) || (step == STEP_W'(7)) || (step == STEP_W'(14));

  always_comb begin
    c_nxt = c;
    d_nxt = d;
    if (dir) begin
      c_nxt = rotr(c, one_shift);
      d_nxt = rotr(d, one_shift);
    end else begin
      c_nxt = rotl(c, one_shift);
      d_nxt = rotl(d, one_shift);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      step  <= '0;
      dir   <= 1'b0;
      ROUND <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (KEY_VALID) begin
            // Decrypt starts from C0D0 (== C16D16); encrypt pre-rotates to C1D1.
            if (DECRYPT) begin
              c <= key_cd[CD_W-1:HALF_W];
              d <= key_cd[HALF_W-1:0];
            end else begin
              c <= rotl(key_cd[CD_W-1:HALF_W], 1'b1);
              d <= rotl(key_cd[HALF_W-1:0], 1'b1);
            end
            dir   <= DECRYPT;
            step  <= '0;
            ROUND <= DECRYPT ? LAST_STEP : '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (step == LAST_STEP) begin
              state <= IDLE;
              DONE  <= 1'b1;
            end else begin
              c     <= c_nxt;
              d     <= d_nxt;
              step  <= step + STEP_W'(1);
              ROUND <= dir ? ROUND - STEP_W'(1) : ROUND + STEP_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: known-answer subkeys, ordering, stalls, busy keys, reset abort.
module tb_des_key_schedule;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [63:0] KEY;
  logic        DECRYPT;
  logic        KEY_VALID;
  logic        KEY_READY;
  logic [47:0] SUBKEY;
  logic        SUBKEY_VALID;
  logic        SUBKEY_READY;
  logic [3:0]  ROUND;
  logic        DONE;

  int vectors = 0;
  int miscompares = 0;

  logic [47:0] exp_k [16];
  logic [63:0] busy_key;

  localparam logic [47:0] HAND_K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam int M_PC1 [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4
  };
  localparam int M_PC2 [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32
  };

  des_key_schedule dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .KEY          (KEY),
    .DECRYPT      (DECRYPT),
    .KEY_VALID    (KEY_VALID),
    .KEY_READY    (KEY_READY),
    .SUBKEY       (SUBKEY),
    .SUBKEY_VALID (SUBKEY_VALID),
    .SUBKEY_READY (SUBKEY_READY),
    .ROUND        (ROUND),
    .DONE         (DONE)
  );

  always #5 CLK = ~CLK;

  // Kn straight from C0D0 using the cumulative left rotation.
  function automatic logic [47:0] model_k(input logic [63:0] key, input int n);
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] k;
    int rot;
    for (int j = 1; j <= 56; j++) cd[j] = key[64 - M_PC1[j-1]];
    c = cd[1:28];
    d = cd[29:56];
    rot = 0;
    for (int r = 1; r <= n; r++) rot += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
    for (int r = 0; r < rot; r++) begin
      c = {c[2:28], c[1]};
      d = {d[2:28], d[1]};
    end
    for (int j = 1; j <= 48; j++)
      k[j] = (M_PC2[j-1] <= 28) ? c[M_PC2[j-1]] : d[M_PC2[j-1] - 28];
    return k;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic load_hand();
    for (int i = 0; i < 16; i++) exp_k[i] = HAND_K[i];
  endtask

  task automatic load_model(input logic [63:0] key);
    for (int i = 0; i < 16; i++) exp_k[i] = model_k(key, i + 1);
  endtask

  task automatic start_key(input logic [63:0] key, input logic dec);
    @(negedge CLK);
    check("key_ready_before_offer", 64'(KEY_READY), 64'd1);
    KEY = key;
    DECRYPT = dec;
    KEY_VALID = 1'b1;
    @(negedge CLK);
    KEY_VALID = 1'b0;
  endtask

  // Called on the negedge where the first subkey should be visible.
  task automatic consume(input logic dec, input logic rnd, input logic busy);
    int n;
    int cyc;
    int r;
    logic rdy;
    n = 0;
    cyc = 0;
    if (busy) begin
      KEY = busy_key;
      DECRYPT = 1'b0;
      KEY_VALID = 1'b1;
    end
    while (n < 16 && cyc < 300) begin
      r = dec ? 15 - n : n;
      check("subkey_valid", 64'(SUBKEY_VALID), 64'd1);
      check("round", 64'(ROUND), 64'(r));
      check("subkey", 64'(SUBKEY), 64'(exp_k[r]));
      check("done_low_in_run", 64'(DONE), 64'd0);
      if (busy) check("key_ready_busy", 64'(KEY_READY), 64'd0);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      SUBKEY_READY = rdy;
      @(negedge CLK);
      if (rdy) n++;
      cyc++;
    end
    check("transfer_count", 64'(n), 64'd16);
    SUBKEY_READY = 1'b0;
    check("done_pulse", 64'(DONE), 64'd1);
    check("key_ready_at_done", 64'(KEY_READY), 64'd1);
    check("valid_low_at_done", 64'(SUBKEY_VALID), 64'd0);
    @(negedge CLK);
    if (busy) KEY_VALID = 1'b0;
    check("done_single_cycle", 64'(DONE), 64'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    KEY = '0;
    DECRYPT = 1'b0;
    KEY_VALID = 1'b0;
    SUBKEY_READY = 1'b0;
    busy_key = 64'h0E329232EA6D0D73;
    #1;
    check("rst_key_ready", 64'(KEY_READY), 64'd1);
    check("rst_subkey_valid", 64'(SUBKEY_VALID), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_round", 64'(ROUND), 64'd0);
    check("rst_subkey", 64'(SUBKEY), 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Encrypt and decrypt with ready held high.
    load_hand();
    start_key(64'h133457799BBCDFF1, 1'b0);
    consume(1'b0, 1'b0, 1'b0);
    start_key(64'h133457799BBCDFF1, 1'b1);
    consume(1'b1, 1'b0, 1'b0);

    // Random back-pressure in both directions.
    start_key(64'h133457799BBCDFF1, 1'b0);
    consume(1'b0, 1'b1, 1'b0);
    start_key(64'h133457799BBCDFF1, 1'b1);
    consume(1'b1, 1'b1, 1'b0);

    // Parity-only key difference, another key offered while busy, taken in the DONE cycle.
    start_key(64'h123456789ABCDEF1, 1'b0);
    consume(1'b0, 1'b0, 1'b1);
    load_model(busy_key);
    consume(1'b0, 1'b1, 1'b0);

    // Reset after the 5th transfer aborts the schedule.
    load_hand();
    start_key(64'h133457799BBCDFF1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      SUBKEY_READY = 1'b1;
      @(negedge CLK);
    end
    SUBKEY_READY = 1'b0;
    check("pre_reset_round", 64'(ROUND), 64'd5);
    check("pre_reset_subkey", 64'(SUBKEY), 64'(HAND_K[5]));
    RST_N = 1'b0;
    #1;
    check("abort_key_ready", 64'(KEY_READY), 64'd1);
    check("abort_subkey_valid", 64'(SUBKEY_VALID), 64'd0);
    check("abort_round", 64'(ROUND), 64'd0);
    check("abort_subkey", 64'(SUBKEY), 64'd0);
    check("abort_done", 64'(DONE), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("no_done_after_abort", 64'(DONE), 64'd0);
    load_model(64'h0E329232EA6D0D73);
    start_key(64'h0E329232EA6D0D73, 1'b0);
    consume(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
